// File: rtl/uart_tx_fifo_param_pkg.sv
// Shared encodings and helpers for the FIFO-fed UART transmitter.
package uart_tx_fifo_param_pkg;

  localparam int MIN_DATA_BITS = 5;

  typedef enum logic [2:0] {
    PAR_NONE  = 3'd0,
    PAR_EVEN  = 3'd1,
    PAR_ODD   = 3'd2,
    PAR_MARK  = 3'd3,
    PAR_SPACE = 3'd4
  } parity_e;

  // LOAD is the one-cycle gap between popping from idle and driving the start bit.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  // Clamp a requested frame width into MIN_DATA_BITS..max_bits.
  function automatic logic [3:0] clamp_bits(input logic [3:0] req, input logic [3:0] max_bits);
    if (req < 4'(MIN_DATA_BITS)) return 4'(MIN_DATA_BITS);
    if (req > max_bits) return max_bits;
    return req;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_param_sync_fifo.sv
// Single-clock FIFO; full/empty derived from an occupancy counter.
module uart_sync_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [W-1:0]             i_din,
  input  logic                     i_pop,
  output logic [W-1:0]             o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_cnt;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty   = (r_cnt == '0);
  assign o_level   = r_cnt;
  assign o_dout    = r_mem[r_rd];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  // Storage is not reset; a flush is just a pointer/count reset.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr] <= i_din;
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo_param.sv
// UART transmitter: input FIFO, per-frame latched config, baud divider, frame FSM.
module uart_tx_fifo_param
  import uart_tx_fifo_param_pkg::*;
#(
  parameter int DATA_W     = 9,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_tx_en,
  input  logic [DIV_W-1:0]              i_baud_div,
  input  logic [3:0]                    i_data_bits,
  input  logic [2:0]                    i_parity_mode,
  input  logic                          i_stop2,
  input  logic                          i_s_valid,
  input  logic [DATA_W-1:0]             i_s_data,
  output logic                          o_s_ready,
  output logic                          o_txd,
  output logic                          o_tx_busy,
  output logic                          o_tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

  localparam logic [3:0] MAX_BITS = 4'(DATA_W);

  logic              w_full;
  logic              w_empty;
  logic [DATA_W-1:0] w_head;
  logic              w_pop;
  logic              w_bit_end;
  logic              w_stop_last;
  logic [3:0]        w_n;
  logic [DATA_W-1:0] w_word;
  logic              w_even;
  logic              w_par;
  logic              w_par_en;

  state_e            r_state;
  logic [DIV_W-1:0]  r_baud;
  logic [DIV_W-1:0]  r_div;
  logic [3:0]        r_bit;
  logic [3:0]        r_n;
  logic [DATA_W-1:0] r_sh;
  logic              r_par;
  logic              r_par_en;
  logic              r_stop2;
  logic              r_stop_cnt;
  logic              r_txd;
  logic              r_busy;
  logic              r_done;

  uart_sync_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (i_s_valid),
    .i_din   (i_s_data),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (o_fifo_level)
  );

  assign o_s_ready = ~w_full;
  assign o_txd     = r_txd;
  assign o_tx_busy = r_busy;
  assign o_tx_done = r_done;

  assign w_bit_end   = (r_baud == '0);
  assign w_stop_last = (r_state == ST_STOP) && w_bit_end && (!r_stop2 || r_stop_cnt);
  assign w_pop       = i_tx_en && !w_empty && ((r_state == ST_IDLE) || w_stop_last);

  // Next-frame settings from the live inputs: clamp width, mask unused bits, pick parity.
  always_comb begin
    w_n    = clamp_bits(i_data_bits, MAX_BITS);
    w_word = '0;
    for (int i = 0; i < DATA_W; i++)
      if (i < int'(w_n)) w_word[i] = w_head[i];
    w_even   = ^w_word;
    w_par_en = 1'b1;
    w_par    = w_even;
    case (i_parity_mode)
      PAR_EVEN:  w_par = w_even;
      PAR_ODD:   w_par = ~w_even;
      PAR_MARK:  w_par = 1'b1;
      PAR_SPACE: w_par = 1'b0;
      default: begin
        w_par_en = 1'b0;
        w_par    = 1'b0;
      end
    endcase
  end

  // Frame FSM: every state lasts r_div+1 cycles; txd/busy/done registered.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_baud     <= '0;
      r_div      <= '0;
      r_bit      <= '0;
      r_n        <= 4'(MIN_DATA_BITS);
      r_sh       <= '0;
      r_par      <= 1'b0;
      r_par_en   <= 1'b0;
      r_stop2    <= 1'b0;
      r_stop_cnt <= 1'b0;
      r_txd      <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_pop) begin
        r_sh     <= w_word;
        r_n      <= w_n;
        r_par    <= w_par;
        r_par_en <= w_par_en;
        r_stop2  <= i_stop2;
        r_div    <= i_baud_div;
      end
      case (r_state)
        ST_IDLE: if (w_pop) r_state <= ST_LOAD;
        ST_LOAD: begin
          r_state <= ST_START;
          r_txd   <= 1'b0;
          r_busy  <= 1'b1;
          r_baud  <= r_div;
        end
        ST_START: begin
          if (w_bit_end) begin
            r_state <= ST_DATA;
            r_txd   <= r_sh[0];
            r_sh    <= r_sh >> 1;
            r_bit   <= '0;
            r_baud  <= r_div;
          end else r_baud <= r_baud - 1'b1;
        end
        ST_DATA: begin
          if (w_bit_end) begin
            r_baud <= r_div;
            if (r_bit == r_n - 4'd1) begin
              if (r_par_en) begin
                r_state <= ST_PARITY;
                r_txd   <= r_par;
              end else begin
                r_state    <= ST_STOP;
                r_txd      <= 1'b1;
                r_stop_cnt <= 1'b0;
              end
            end else begin
              r_bit <= r_bit + 4'd1;
              r_txd <= r_sh[0];
              r_sh  <= r_sh >> 1;
            end
          end else r_baud <= r_baud - 1'b1;
        end
        ST_PARITY: begin
          if (w_bit_end) begin
            r_state    <= ST_STOP;
            r_txd      <= 1'b1;
            r_stop_cnt <= 1'b0;
            r_baud     <= r_div;
          end else r_baud <= r_baud - 1'b1;
        end
        ST_STOP: begin
          if (w_bit_end) begin
            if (r_stop2 && !r_stop_cnt) begin
              r_stop_cnt <= 1'b1;
              r_baud     <= r_div;
            end else begin
              r_done <= 1'b1;
              if (w_pop) begin
                // Chained frame: start bit follows the last stop bit with no gap.
                r_state <= ST_START;
                r_txd   <= 1'b0;
                r_baud  <= i_baud_div;
              end else begin
                r_state <= ST_IDLE;
                r_txd   <= 1'b1;
                r_busy  <= 1'b0;
              end
            end
          end else r_baud <= r_baud - 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
